// File: rtl/mul4_pkg.sv
// mul4_pkg: shared constants, FSM state type and golden-model helpers for the
// mul4 tournament fitness sequencer.
//   W, NV_W, SC_W, BUS_W  word width, vector-count width, score width, bus width
//   LFSR_TAPS             Galois feedback mask applied on a right shift
//   state_t               sequencer states
//   golden_words()        64-bit reference product {a1,a0} * {b1,b0}
//   match_count()         number of equal 16-bit words between two 64-bit values
package mul4_pkg;

  localparam int W     = 16;
  localparam int NV_W  = 8;
  localparam int SC_W  = NV_W + 3;
  localparam int BUS_W = 4 * W;

  localparam logic [BUS_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [BUS_W-1:0] golden_words(
    input logic [W-1:0] a1,
    input logic [W-1:0] a0,
    input logic [W-1:0] b1,
    input logic [W-1:0] b0
  );
    logic [BUS_W-1:0] a_ext;
    logic [BUS_W-1:0] b_ext;
    a_ext = {{(2*W){1'b0}}, a1, a0};
    b_ext = {{(2*W){1'b0}}, b1, b0};
    return a_ext * b_ext;
  endfunction

  function automatic logic [2:0] match_count(
    input logic [BUS_W-1:0] p,
    input logic [BUS_W-1:0] y
  );
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (p[i*W +: W] == y[i*W +: W]) n = n + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/mul4_vec_lfsr.sv
// mul4_vec_lfsr: 64-bit right-shifting Galois LFSR that generates the operand
// vectors. A zero seed would lock the register at zero, so it becomes 1.
//   clk, rst   clock, asynchronous active-high reset
//   load       load seed (takes priority over advance)
//   seed       seed value
//   advance    step the LFSR once
//   value      current LFSR state
module mul4_vec_lfsr
  import mul4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BUS_W-1:0] seed,
  input  logic             advance,
  output logic [BUS_W-1:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= {{(BUS_W-1){1'b0}}, 1'b1};
    end else if (load) begin
      value <= (seed == '0) ? {{(BUS_W-1){1'b0}}, 1'b1} : seed;
    end else if (advance) begin
      value <= {1'b0, value[BUS_W-1:1]} ^ (value[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/mul4_tournament_ctrl.sv
// mul4_tournament_ctrl: applies pseudo-random operand vectors to two
// combinational candidate multipliers, scores each against the golden
// 32x32 product and reports the winner.
//   clk, rst          clock, asynchronous active-high reset
//   start             begin evaluation (accepted only in IDLE)
//   num_vec, seed     vector count (0 = 2^NV_W) and LFSR seed, sampled with start
//   a1,a0,b1,b0       shared operand bus, zero outside RUN
//   c0_y, c1_y        candidate outputs {y3,y2,y1,y0}
//   busy, done        busy in RUN/DRAIN; done is a one-cycle pulse in DONE
//   score0, score1    word-match counts; winner = (score1 > score0)
//
// Host handshake: start is a request sampled only while idle (busy=0 and
// done=0); requests at any other time are dropped, never queued. Completion
// is signalled by the single done pulse; scores and winner stay stable from
// that pulse until the next accepted start.
module mul4_tournament_ctrl
  import mul4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NV_W-1:0]  num_vec,
  input  logic [BUS_W-1:0] seed,
  output logic [W-1:0]     a1,
  output logic [W-1:0]     a0,
  output logic [W-1:0]     b1,
  output logic [W-1:0]     b0,
  input  logic [BUS_W-1:0] c0_y,
  input  logic [BUS_W-1:0] c1_y,
  output logic             busy,
  output logic             done,
  output logic [SC_W-1:0]  score0,
  output logic [SC_W-1:0]  score1,
  output logic             winner
);

  state_t            state;
  state_t            next_state;
  logic [NV_W-1:0]   cnt;
  logic [BUS_W-1:0]  lfsr_q;
  logic              accept;

  logic              stg_valid;
  logic [BUS_W-1:0]  stg_bus;
  logic [BUS_W-1:0]  stg_y0;
  logic [BUS_W-1:0]  stg_y1;
  logic [BUS_W-1:0]  golden;

  assign accept = (state == IDLE) && start;

  mul4_vec_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .seed    (seed),
    .advance (state == RUN),
    .value   (lfsr_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // A zero count loads as 0 and wraps through 2^NV_W-1 .. 1, so the last
  // vector is always the one issued while the counter reads 1.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (cnt == {{(NV_W-1){1'b0}}, 1'b1}) next_state = DRAIN;
      DRAIN:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign {a1, a0, b1, b0} = (state == RUN) ? lfsr_q : '0;
  assign busy   = (state == RUN) || (state == DRAIN);
  assign done   = (state == DONE);
  assign winner = (score1 > score0);

  assign golden = golden_words(stg_bus[4*W-1:3*W], stg_bus[3*W-1:2*W],
                               stg_bus[2*W-1:W],   stg_bus[W-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      stg_valid <= 1'b0;
      stg_bus   <= '0;
      stg_y0    <= '0;
      stg_y1    <= '0;
      score0    <= '0;
      score1    <= '0;
    end else begin
      stg_valid <= (state == RUN);
      if (state == RUN) begin
        cnt     <= cnt - 1'b1;
        stg_bus <= {a1, a0, b1, b0};
        stg_y0  <= c0_y;
        stg_y1  <= c1_y;
      end
      if (accept) begin
        cnt    <= num_vec;
        score0 <= '0;
        score1 <= '0;
      end else if (stg_valid) begin
        score0 <= score0 + {{(SC_W-3){1'b0}}, match_count(golden, stg_y0)};
        score1 <= score1 + {{(SC_W-3){1'b0}}, match_count(golden, stg_y1)};
      end
    end
  end

endmodule

// File: doc/mul4_tournament_ctrl.md
# mul4_tournament_ctrl

Fitness-evaluation sequencer for evolved mul4_vector candidates in tournament selection. It drives a shared 4×16-bit operand bus into two combinational candidate individuals and checks each candidate's four 16-bit output words against a golden 32×32 unsigned product. It accumulates one match score per candidate over a programmable number of pseudo-random vectors, then reports the winner. It sits between the tournament host (start/score handshake) and the two candidate instances under evaluation.

## Interface
- W, 16, word width of each operand/result word
- NV_W, 8, width of num_vec; vector count range 1..2^NV_W
- SC_W, NV_W+3, score width (max 4·2^NV_W matches)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin evaluation; sampled only in IDLE
- num_vec  in  NV_W  vectors to apply; 0 means 2^NV_W; sampled with start
- seed  in  4W  LFSR seed; sampled with start; 0 is replaced by 64'h1
- a1, a0, b1, b0  out  W each  shared operand bus to both candidates; {a1,a0,b1,b0} = LFSR state
- c0_y  in  4W  candidate 0 outputs packed {y3,y2,y1,y0}
- c1_y  in  4W  candidate 1 outputs packed {y3,y2,y1,y0}
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse, in DONE only
- score0, score1  out  SC_W  accumulated word matches per candidate
- winner  out  1  0 if score0 >= score1, else 1; valid from done onward

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start.
  - RUN→DRAIN after the last vector is issued.
  - DRAIN→DONE unconditionally.
  - DONE→IDLE unconditionally.
- On start:
  - load LFSR with seed (or 1 if seed==0), load the vector down-counter with num_vec, clear both scores.
- RUN:
  - drive the bus from LFSR state.
  - At each clock edge, capture {a1,a0,b1,b0,c0_y,c1_y} into a stage register with a valid bit, advance the LFSR, and decrement the counter.
- LFSR: 64-bit Galois, right shift. next = (s>>1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 0).
- Compare stage, on valid stage register:
  - P = {a1,a0} * {b1,b0}, unsigned, 64-bit.
  - For each candidate, count equal 16-bit words of P vs c*_y (0..4) and add to its score.
- Scores never saturate; SC_W guarantees no overflow.
- Operand bus drives 0 outside RUN.
- Scores and winner hold from DONE until the next start clears them.
- start in RUN/DRAIN/DONE is ignored, with no queuing.
- Reset values: state IDLE; a1/a0/b1/b0 = 0; busy = 0; done = 0; score0 = score1 = 0; winner = 0; stage valid = 0.
- Reset mid-run: abort immediately with reset values; no done pulse.

## Timing
- start high in IDLE at cycle T0. Then, for N = effective vector count:
  - T1: RUN begins, vector 0 on bus.
  - Vector k is on the bus at T1+k, k = 0..N-1.
  - Vector k sits in the stage register during T2+k; its matches are added at the end of T2+k.
  - DRAIN at T1+N.
  - DONE (done=1, busy=0, final scores and winner) at T2+N.
  - IDLE at T3+N; the earliest new start is accepted at T3+N.
- Candidates are combinational. c*_y must settle within the cycle the vector is driven.
- The golden multiply is single-cycle from the stage register. No further pipelining.

## Structure
- Package mul4_pkg holds:
  - W and the derived constants.
  - LFSR tap mask 64'hD800_0000_0000_0000.
  - FSM state enum (IDLE, RUN, DRAIN, DONE).
  - A function golden_words(a1,a0,b1,b0) returning the packed 64-bit product.
  - A function match_count(p, y) returning 0..4.
- Sub-module mul4_vec_lfsr: 64-bit Galois LFSR with load/seed/advance ports and zero-seed substitution.

## Test plan
- Scoring: num_vec=4, seed=64'h1234_5678_9ABC_DEF0; c0 = golden model; c1 = golden with y3 inverted -> score0=16, score1=12, winner=0, done at T6.
- Full-count tie: num_vec=0 (256 vectors), both candidates golden -> score0=score1=1024, winner=0, busy T1..T257, done at T258.
- Zero seed: seed=0, num_vec=1, both candidates output 0 -> bus at T1 = a1=a0=b1=0, b0=1. P=0, so score0=score1=4. Next LFSR state after advance = 64'hD800_0000_0000_0000.
- Start while busy: pulse start at T3 of a num_vec=8 run -> no restart, done exactly at T10, and only one done pulse.
- Reset mid-run: assert rst at T3 -> next edge shows busy=0, scores=0, bus=0, and no done pulse. A fresh start afterwards completes normally.
- Winner selection: c0 always outputs 0, c1 golden, num_vec=2 -> score1=8, score0 < 8, winner=1 at done.
